// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned/signed subtractor: A - B computed LSB first as A + ~B + 1,
// one bit per clock, with a valid/ready handshake on both sides.
module bit_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             borrow_q;
    logic             ovf_q;

    logic             a_bit;
    logic             nb_bit;
    logic             sum_bit;
    logic             c_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] wide;

    always_comb begin
        a_bit    = a_sh[0];
        nb_bit   = ~b_sh[0];
        sum_bit  = a_bit ^ nb_bit ^ carry;
        c_nxt    = (a_bit & nb_bit) | (a_bit & carry) | (nb_bit & carry);
        last_bit = (cnt == LAST);
        wide     = {sum_bit, res};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: if (last_bit) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            diff_q   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= minuend;
                        b_sh  <= subtrahend;
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_nxt;
                    res   <= wide[WIDTH-1:1];
                    cnt   <= cnt + 1'b1;
                    // carry still holds the carry into the MSB on the last bit
                    if (last_bit) begin
                        diff_q   <= wide;
                        borrow_q <= ~c_nxt;
                        ovf_q    <= carry ^ c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign difference = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed-vector bench for bit_serial_subtractor at WIDTH = 8.
module tb_bit_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] minuend;
    logic [W-1:0] subtrahend;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] difference;
    logic         borrow_out;
    logic         overflow;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .difference (difference),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, wait for the result, check it, then drain it.
    task automatic run(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ed,
                       input logic eb, input logic eo);
        int cyc;
        check({tag, "_pre_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        minuend    = a;
        subtrahend = b;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, W);
        check({tag, "_diff"}, {24'd0, difference}, {24'd0, ed});
        check({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, eb});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int cyc;
        int nres;
        int last_cyc;
        logic bad;
        logic overlap;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        minuend    = '0;
        subtrahend = '0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_diff", {24'd0, difference}, 32'd0);
        check("rst_flags", {30'd0, borrow_out, overflow}, 32'd0);
        rst_n = 1'b1;
        tick();

        run("v50_20", 8'h50, 8'h20, 8'h30, 1'b0, 1'b0);
        run("v10_20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run("v80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run("v7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run("v00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Stall in DONE while offering new operands.
        in_valid   = 1'b1;
        minuend    = 8'h33;
        subtrahend = 8'h11;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("hold_latency", cyc, W);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            minuend    = 8'hAA;
            subtrahend = 8'h01;
            tick();
            if (difference !== 8'h22 || in_ready !== 1'b0 ||
                out_valid !== 1'b1 || borrow_out !== 1'b0 ||
                overflow !== 1'b0)
                bad = 1'b1;
        end
        check("hold_stable", {31'd0, bad}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_release", {29'd0, in_ready, out_valid, busy}, 32'd4);
        tick();
        check("hold_not_consumed", {31'd0, busy}, 32'd0);

        // Reset in IDLE beats a simultaneous handshake.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("rst_prio_busy", {31'd0, busy}, 32'd0);
        check("rst_prio_diff", {24'd0, difference}, 32'd0);

        // Previous result left in difference, then reset while at bit 3.
        run("v09_04", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);
        in_valid   = 1'b1;
        minuend    = 8'hFF;
        subtrahend = 8'h01;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_ready", {30'd0, in_ready, out_valid}, 32'd2);
        check("mid_rst_diff", {24'd0, difference}, 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        check("mid_no_result", {31'd0, bad}, 32'd0);
        run("v05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

        // Back-to-back with both handshakes held high.
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        minuend    = 8'h09;
        subtrahend = 8'h04;
        nres     = 0;
        last_cyc = -1;
        bad      = 1'b0;
        overlap  = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (in_ready && out_valid) overlap = 1'b1;
            if (out_valid) begin
                if (difference !== 8'h05) bad = 1'b1;
                if (last_cyc >= 0 && (i - last_cyc) != W + 2) bad = 1'b1;
                last_cyc = i;
                nres++;
            end
        end
        check("b2b_count", nres, 4);
        check("b2b_period_data", {31'd0, bad}, 32'd0);
        check("b2b_overlap", {31'd0, overlap}, 32'd0);
        in_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 50) begin
            tick();
            cyc++;
        end
        check("b2b_drain", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serial_subtractor.md
BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits; legal values are WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have port minuend, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port subtrahend, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 The block SHALL have port difference, output, WIDTH bits: A - B modulo 2^WIDTH.
REQ-011 The block SHALL have port borrow_out, output, 1 bit: 1 when A < B as unsigned values.
REQ-012 The block SHALL have port overflow, output, 1 bit: 1 when A - B overflows as two's-complement signed.
REQ-013 The block SHALL have port busy, output, 1 bit: high in CALC or DONE.

Function
REQ-014 The block SHALL implement the three-state FSM IDLE, CALC, DONE with all outputs registered or decoded from registered state only.
REQ-015 In IDLE: in_ready = 1, out_valid = 0; an input transfer occurs on a rising edge where in_valid = 1 and in_ready = 1.
REQ-016 On an input transfer: capture minuend and subtrahend into shift registers; set the carry register to 1; clear the bit counter; go to CALC.
REQ-017 In CALC the block SHALL process one bit per cycle, LSB first, using full-adder logic on A[i], ~B[i] and the carry.
REQ-018 On each CALC edge: sum bit = A[i] ^ ~B[i] ^ c; c <= majority(A[i], ~B[i], c); shift the sum into the result register from the MSB side; increment the counter.
REQ-019 The carry into the MSB SHALL be retained when bit WIDTH-1 is processed.
REQ-020 After the edge that processes bit WIDTH-1, the block SHALL enter DONE.
REQ-021 Timing: out_valid SHALL first be high exactly WIDTH cycles after the input-transfer edge.
REQ-022 On entry to DONE: borrow_out = ~(final carry); overflow = (carry into MSB) XOR (final carry).
REQ-023 In DONE: out_valid = 1, in_ready = 0; difference, borrow_out and overflow SHALL hold stable until a rising edge with out_ready = 1.
REQ-024 On a DONE edge with out_ready = 1 the block SHALL return to IDLE; the next operand is accepted no earlier than the following edge (no same-cycle turnaround).
REQ-025 in_valid and operand inputs SHALL be ignored in CALC and DONE.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 Results SHALL keep their last values in IDLE after a completed transfer; only out_valid distinguishes valid data.

Reset
REQ-028 On a rising edge with rst_n = 0, from any state including mid-CALC, the block SHALL enter IDLE.
REQ-029 Reset values: in_ready = 1; out_valid, busy, difference, borrow_out and overflow = 0; counter, carry and operand registers = 0.
REQ-030 A partially computed result SHALL be discarded on reset and never presented.
REQ-031 Reset SHALL take priority over any simultaneous handshake.

Verification (WIDTH = 8)
REQ-032 Scenario: accept 0x50 - 0x20 -> out_valid high 8 cycles after accept; difference 0x30, borrow_out 0, overflow 0.
REQ-033 Scenario: 0x10 - 0x20 -> difference 0xF0, borrow_out 1, overflow 0; 0x80 - 0x01 -> difference 0x7F, borrow_out 0, overflow 1.
REQ-034 Scenario: 0x7F - 0xFF -> difference 0x80, borrow_out 1, overflow 1; 0x00 - 0x00 -> difference 0x00, borrow_out 0, overflow 0.
REQ-035 Scenario: hold out_ready = 0 for 5 cycles in DONE while pulsing in_valid with new operands -> outputs unchanged, in_ready 0; on out_ready = 1, IDLE next cycle; the new operands are not consumed.
REQ-036 Scenario: rst_n = 0 for one edge at CALC bit 3 -> next cycle IDLE, in_ready 1, out_valid 0, difference 0x00; the following 0x05 - 0x03 yields 0x02.
REQ-037 Scenario: back-to-back transfers with out_ready tied 1 -> one result per WIDTH+2 cycles; in_ready never high in the same cycle as out_valid.
